fm_mod_source_arbiter: RTL and testbench

//   Parametrised N-source FM modulation arbiter; successor to the fixed two-way PWM/melody select.

---
 rtl/fm_arb_pkg.sv | 23 ++
 rtl/fm_src_activity.sv | 39 +++
 rtl/fm_mod_source_arbiter.sv | 137 +++++++++++++
 tb/tb_fm_mod_source_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fm_arb_pkg.sv
// Shared constants, FSM state encoding and width helpers for the FM modulation source arbiter.
package fm_arb_pkg;

  typedef logic [1:0] fm_state_t;
  localparam fm_state_t IDLE   = 2'd0;
  localparam fm_state_t SWITCH = 2'd1;
  localparam fm_state_t LOCK   = 2'd2;

  localparam int          N_SRC_DEF     = 4;
  localparam logic [31:0] BASE_INC_DEF  = 32'h4000_0000;
  localparam logic [31:0] DEV_SCALE_DEF = 32'h0000_9A5E;
  localparam logic [31:0] SLEW_STEP_DEF = 32'h0001_0000;

  // Index width that stays legal for a single-source build.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fm_src_activity.sv
// One modulation source: timeout counter that tracks activity plus the latched sample.
module fm_src_activity
  import fm_arb_pkg::*;
#(
  parameter int SAMPLE_W    = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       valid,
  input  logic                       mask,
  input  logic signed [SAMPLE_W-1:0] src_sample,
  output logic signed [SAMPLE_W-1:0] held_sample,
  output logic                       active
);

  localparam int CW = cnt_w(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  // Stage p1: sample latch and countdown, visible to the arbiter one cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      held_sample <= '0;
    end else if (!enable || !mask) begin
      cnt <= '0;
    end else if (valid) begin
      cnt         <= CW'(TIMEOUT_CYC);
      held_sample <= src_sample;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign active = (cnt != '0);

endmodule

// File: rtl/fm_mod_source_arbiter.sv
// N-source FM arbiter: priority select with hold-off, sample-to-increment scaling and switch slew.
// Define FM_ARB_SLEW_EN to glide phase_inc on switches; otherwise increments jump directly.
module fm_mod_source_arbiter
  import fm_arb_pkg::*;
#(
  parameter int               N_SRC       = N_SRC_DEF,
  parameter int               SAMPLE_W    = 16,
  parameter int               ACC_W       = 32,
  parameter int               TIMEOUT_CYC = 255,
  parameter int               HOLD_CYC    = 1024,
  parameter logic [ACC_W-1:0] BASE_INC    = ACC_W'(BASE_INC_DEF),
  parameter logic [ACC_W-1:0] DEV_SCALE   = ACC_W'(DEV_SCALE_DEF),
  parameter logic [ACC_W-1:0] SLEW_STEP   = ACC_W'(SLEW_STEP_DEF),
  localparam int              IDX_W       = idx_w(N_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [N_SRC*SAMPLE_W-1:0] src_sample,
  input  logic [N_SRC-1:0]          src_valid,
  input  logic [N_SRC-1:0]          src_mask,
  output logic [ACC_W-1:0]          phase_inc,
  output logic                      phase_inc_valid,
  output logic [IDX_W-1:0]          active_src,
  output logic [N_SRC-1:0]          src_active
);

`ifdef FM_ARB_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  localparam int HW = cnt_w(HOLD_CYC);
  localparam int PW = SAMPLE_W + ACC_W + 1;
  localparam logic signed [ACC_W-1:0] STEP_S = SLEW_STEP;

  logic signed [SAMPLE_W-1:0] sample_p1 [N_SRC];
  fm_state_t                  state, state_n;
  logic [IDX_W-1:0]           low_idx, sel_n;
  logic                       any_active;
  logic [HW-1:0]              hold;
  logic [ACC_W-1:0]           tgt_cur, tgt_n, inc_n;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    fm_src_activity #(
      .SAMPLE_W   (SAMPLE_W),
      .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_act (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .valid      (src_valid[i]),
      .mask       (src_mask[i]),
      .src_sample (src_sample[i*SAMPLE_W +: SAMPLE_W]),
      .held_sample(sample_p1[i]),
      .active     (src_active[i])
    );
  end

  // Centre increment plus signed deviation; the Q16 product is floored and the sum wraps.
  function automatic logic [ACC_W-1:0] scale_target(input logic signed [SAMPLE_W-1:0] s);
    logic signed [PW-1:0] prod;
    prod = PW'(s) * PW'($signed({1'b0, DEV_SCALE}));
    return BASE_INC + ACC_W'(prod >>> 16);
  endfunction

  // One slew step toward goal along the shorter modular direction; lands on goal when close.
  function automatic logic [ACC_W-1:0] glide(input logic [ACC_W-1:0] cur, input logic [ACC_W-1:0] goal);
    logic signed [ACC_W-1:0] diff;
    diff = $signed(goal - cur);
    if (SLEW_ON && diff > STEP_S)  return cur + SLEW_STEP;
    if (SLEW_ON && diff < -STEP_S) return cur - SLEW_STEP;
    return goal;
  endfunction

  always_comb begin : prio
    any_active = |src_active;
    low_idx    = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (src_active[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin : fsm_next
    state_n = state;
    sel_n   = active_src;
    tgt_cur = scale_target(sample_p1[active_src]);
    case (state)
      IDLE: begin
        if (any_active) begin
          state_n = SWITCH;
          sel_n   = low_idx;
        end
      end
      SWITCH, LOCK: begin
        if (!src_active[active_src]) begin
          state_n = any_active ? SWITCH : IDLE;
          if (any_active) sel_n = low_idx;
        end else if (state == SWITCH) begin
          if (glide(phase_inc, tgt_cur) == tgt_cur) state_n = LOCK;
        end else if (low_idx < active_src && hold == '0) begin
          state_n = SWITCH;
          sel_n   = low_idx;
        end
      end
      default: state_n = IDLE;
    endcase
    tgt_n = scale_target(sample_p1[sel_n]);
    if (state_n == IDLE)      inc_n = glide(phase_inc, BASE_INC);
    else if (state_n == LOCK) inc_n = tgt_n;
    else                      inc_n = glide(phase_inc, tgt_n);
  end

  // Stage p2: registered increment, selection and hold-off toward the modulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      active_src      <= '0;
      hold            <= '0;
      phase_inc       <= BASE_INC;
      phase_inc_valid <= 1'b0;
    end else if (!enable) begin
      state           <= IDLE;
      phase_inc       <= BASE_INC;
      phase_inc_valid <= 1'b0;
    end else begin
      state           <= state_n;
      active_src      <= sel_n;
      phase_inc       <= inc_n;
      phase_inc_valid <= (state_n != IDLE);
      if (state_n == LOCK && state != LOCK) hold <= HW'(HOLD_CYC);
      else if (hold != '0)                  hold <= hold - HW'(1);
    end
  end

endmodule

// File: tb/tb_fm_mod_source_arbiter.sv
// Randomized bench for fm_mod_source_arbiter against a cycle-level behavioural model.
module tb_fm_mod_source_arbiter;

  localparam int          N       = 4;
  localparam int          TIMEOUT = 255;
  localparam int          HOLD    = 1024;
  localparam logic [31:0] BASE    = 32'h4000_0000;
  localparam logic [31:0] DEV     = 32'h0000_9A5E;
  localparam logic [31:0] STEP    = 32'h0001_0000;
`ifdef FM_ARB_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [63:0] src_sample = '0;
  logic [3:0]  src_valid = '0;
  logic [3:0]  src_mask = 4'hF;
  logic [31:0] phase_inc;
  logic        phase_inc_valid;
  logic [1:0]  active_src;
  logic [3:0]  src_active;

  fm_mod_source_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .src_sample     (src_sample),
    .src_valid      (src_valid),
    .src_mask       (src_mask),
    .phase_inc      (phase_inc),
    .phase_inc_valid(phase_inc_valid),
    .active_src     (active_src),
    .src_active     (src_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: remaining live cycles per source, latched samples, mode 0=idle 1=switch 2=lock
  int          m_cnt [N];
  longint      m_smp [N];
  int          m_mode, m_sel, m_age;
  logic [31:0] m_inc;
  bit          m_vld;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_tgt(input longint s);
    longint off;
    off = (s * longint'(DEV)) >>> 16;
    return BASE + off[31:0];
  endfunction

  function automatic logic [31:0] m_glide(input logic [31:0] cur, input logic [31:0] goal);
    longint d;
    d = longint'($signed(goal - cur));
    if (!SLEW || (d <= longint'(STEP) && d >= -longint'(STEP))) return goal;
    return (d > 0) ? cur + STEP : cur - STEP;
  endfunction

  function automatic logic [3:0] m_live();
    logic [3:0] a;
    for (int i = 0; i < N; i++) a[i] = (m_cnt[i] > 0);
    return a;
  endfunction

  function automatic int lowest(input logic [3:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_smp[i] = 0; end
    m_mode = 0; m_sel = 0; m_age = 0; m_inc = BASE; m_vld = 1'b0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] v, input logic [3:0] m, input logic [63:0] smp);
    logic [3:0] live;
    int low, nmode, nsel;
    live = m_live();
    low  = lowest(live);
    if (!en) begin
      m_mode = 0; m_inc = BASE; m_vld = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    nmode = m_mode;
    nsel  = m_sel;
    if (m_mode == 0) begin
      if (low >= 0) begin nmode = 1; nsel = low; end
    end else if (!live[m_sel]) begin
      if (low >= 0) begin nmode = 1; nsel = low; end
      else nmode = 0;
    end else if (m_mode == 1) begin
      if (m_glide(m_inc, m_tgt(m_smp[m_sel])) == m_tgt(m_smp[m_sel])) nmode = 2;
    end else if (low < m_sel && m_age >= HOLD) begin
      nmode = 1; nsel = low;
    end
    m_age = (nmode == 2 && m_mode == 2) ? m_age + 1 : 0;
    if (nmode == 0)      m_inc = m_glide(m_inc, BASE);
    else if (nmode == 2) m_inc = m_tgt(m_smp[nsel]);
    else                 m_inc = m_glide(m_inc, m_tgt(m_smp[nsel]));
    m_vld  = (nmode != 0);
    m_mode = nmode;
    m_sel  = nsel;
    for (int i = 0; i < N; i++) begin
      if (!m[i]) m_cnt[i] = 0;
      else if (v[i]) begin
        m_cnt[i] = TIMEOUT;
        m_smp[i] = longint'($signed(smp[i*16 +: 16]));
      end else if (m_cnt[i] > 0) m_cnt[i]--;
    end
  endtask

  task automatic compare_all();
    check_val("phase_inc", 64'(phase_inc), 64'(m_inc));
    check_val("phase_inc_valid", 64'(phase_inc_valid), 64'(m_vld));
    check_val("active_src", 64'(active_src), 64'(m_sel));
    check_val("src_active", 64'(src_active), 64'(m_live()));
  endtask

  // Called at a negedge: drive, take one clock, advance model, compare at the next negedge
  task automatic run_cycle(input bit en, input logic [3:0] v, input logic [3:0] m, input logic [63:0] smp);
    enable = en; src_valid = v; src_mask = m; src_sample = smp;
    @(posedge clk);
    model_step(en, v, m, smp);
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] rnd_sample();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rnd_samples();
    logic [63:0] s;
    for (int i = 0; i < N; i++) s[i*16 +: 16] = rnd_sample();
    return s;
  endfunction

  initial begin
    logic [3:0] v;
    model_reset();
    repeat (3) begin @(negedge clk); compare_all(); end
    rst_n = 1'b1;
    repeat (5) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Single strobe on source 2 at full scale, then let it time out
    run_cycle(1'b1, 4'b0100, 4'hF, {16'h0, 16'h7FFF, 32'h0});
    repeat (270) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Source 3 held live; source 1 appears mid-hold and must wait for the hold-off
    for (int c = 0; c < 1800; c++) begin
      v = 4'h0;
      if (c % 100 == 0) v[3] = 1'b1;
      if (c >= 600 && c % 100 == 50) v[1] = 1'b1;
      run_cycle(1'b1, v, 4'hF, rnd_samples());
    end
    repeat (300) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Target changes while locked
    for (int c = 0; c < 60; c++) run_cycle(1'b1, (c % 3 == 0) ? 4'b0001 : 4'h0, 4'hF, rnd_samples());

    // Simultaneous first strobes, then source 0 masked away
    repeat (300) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);
    repeat (6) run_cycle(1'b1, 4'b0011, 4'hF, rnd_samples());
    repeat (10) run_cycle(1'b1, 4'b0011, 4'b1110, rnd_samples());
    repeat (300) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Enable dropped right as a switch begins from a full-negative sample
    run_cycle(1'b1, 4'b0001, 4'hF, {48'h0, 16'h8000});
    run_cycle(1'b1, 4'h0, 4'hF, 64'h0);
    run_cycle(1'b0, 4'h0, 4'hF, 64'h0);
    repeat (4) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Async reset while a source is switching in
    run_cycle(1'b1, 4'b0100, 4'hF, rnd_samples());
    run_cycle(1'b1, 4'h0, 4'hF, 64'h0);
    async_reset();
    repeat (3) run_cycle(1'b1, 4'h0, 4'hF, 64'h0);

    // Free-running random traffic with occasional enable and mask glitches
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 15) == 0);
      if (c == 1500) async_reset();
      run_cycle($urandom_range(0, 199) != 0, v,
                ($urandom_range(0, 49) == 0) ? 4'($urandom) : 4'hF, rnd_samples());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
